hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide stage that owns the architectural HI/LO registers. It consumes the same register-file operands as the ALU, so the ALU no longer performs mult/div combinationally. It sits directly downstream of the register-file read and alongside the ALU. Its HI/LO outputs feed the writeback mux for mfhi/mflo, and busy drives the pipeline stall for any HI/LO consumer.

---
 rtl/hilo_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative mult/div that owns the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            dbz;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opb;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             rt_zero;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mq_nx;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    a_neg   = op[0] & read_data_1[WIDTH-1];
    b_neg   = op[0] & read_data_2[WIDTH-1];
    a_mag   = a_neg ? -read_data_1 : read_data_1;
    b_mag   = b_neg ? -read_data_2 : read_data_2;
    rt_zero = (read_data_2 == '0);
  end

  // acc holds the running high product or the partial remainder;
  // mq holds the multiplier or the dividend/quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc};
    if (mq[0]) begin
      mul_sum = {1'b0, acc} + {1'b0, opb};
    end
    div_shift = {acc, mq[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_rem   = div_shift[WIDTH-1:0] - opb;
    acc_nx    = mul_sum[WIDTH:1];
    mq_nx     = {mul_sum[0], mq[WIDTH-1:1]};
    if (is_div) begin
      if (div_ge) begin
        acc_nx = div_rem;
        mq_nx  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = div_shift[WIDTH-1:0];
        mq_nx  = {mq[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -mq : mq;
    rem_fix  = neg_r ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      acc         <= '0;
      mq          <= '0;
      opb         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            acc         <= '0;
            mq          <= a_mag;
            opb         <= b_mag;
            cnt         <= CW'(WIDTH - 1);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            dbz         <= op[1] & rt_zero;
            state       <= (op[1] & rt_zero) ? FIX : RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (dbz) begin
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: transaction-level HI/LO model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .read_data_1(rd1),
    .read_data_2(rd2),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void calc(input logic [1:0] o,
                               input logic [31:0] a, b,
                               output logic [31:0] h, l,
                               output logic z);
    logic [63:0] p;
    longint sa, sb;
    z  = 1'b0;
    h  = '0;
    l  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      2'd1: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      2'd2: begin
        if (b == 0) z = 1'b1;
        else begin
          l = a / b;
          h = a % b;
        end
      end
      default: begin
        if (b == 0) z = 1'b1;
        else begin
          l = 32'(sa / sb);
          h = 32'(sa % sb);
        end
      end
    endcase
  endfunction

  // Transaction model: result appears a fixed number of edges after launch.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done, m_dbz, p_dbz;
  int          m_left;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_hi   = '0;
      m_lo   = '0;
      m_busy = 1'b0;
      m_dbz  = 1'b0;
      m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        if (p_dbz) m_dbz = 1'b1;
        else begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (start) begin
      calc(op, rd1, rd2, p_hi, p_lo, p_dbz);
      m_busy = 1'b1;
      m_dbz  = 1'b0;
      m_left = p_dbz ? 1 : 33;
    end else begin
      if (mthi) m_hi = wdata;
      if (mtlo) m_lo = wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", 32'(busy), 32'(m_busy));
      chk("cyc done", 32'(done), 32'(m_done));
      chk("cyc dbz", 32'(div_by_zero), 32'(m_dbz));
      chk("cyc hi", hi, m_hi);
      chk("cyc lo", lo, m_lo);
    end
  end

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] a, b, input int lat,
                        input logic [31:0] eh, el, input logic ez);
    int   n;
    int   bc;
    logic got;
    op    = o;
    rd1   = a;
    rd2   = b;
    start = 1'b1;
    n     = 0;
    bc    = 0;
    got   = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      n++;
      if (busy) bc++;
      got = done;
    end
    chk({nm, " latency"}, 32'(n - 1), 32'(lat));
    chk({nm, " busy cycles"}, 32'(bc), 32'(lat));
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int   n;
    logic got;
    logic dn;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    rd1   = '0;
    rd2   = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset dbz", 32'(div_by_zero), 32'h0);
    @(negedge clk);

    run_op("multu max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
           32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult -3x7", 2'd1, 32'hFFFFFFFD, 32'h7, 33,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("div -7/2", 2'd3, 32'hFFFFFFF9, 32'h2, 33,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div 7/-2", 2'd3, 32'h7, 32'hFFFFFFFE, 33,
           32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu 100/7", 2'd2, 32'd100, 32'd7, 33,
           32'd2, 32'd14, 1'b0);
    run_op("divu 100/0", 2'd2, 32'd100, 32'd0, 1,
           32'd2, 32'd14, 1'b1);
    repeat (3) @(negedge clk);
    chk("dbz sticky", 32'(div_by_zero), 32'h1);

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthilo done", 32'(done), 32'h0);
    chk("mthilo hi", hi, 32'h12345678);
    chk("mthilo lo", lo, 32'h12345678);
    chk("mthilo dbz kept", 32'(div_by_zero), 32'h1);

    mthi  = 1'b1;
    wdata = 32'hAAAA5555;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi only hi", hi, 32'hAAAA5555);
    chk("mthi only lo", lo, 32'h12345678);

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hDEADBEEF;
    run_op("start beats mthi", 2'd0, 32'd2, 32'd3, 33,
           32'h0, 32'h6, 1'b0);
    run_op("div overflow", 2'd3, 32'h80000000, 32'hFFFFFFFF, 33,
           32'h0, 32'h80000000, 1'b0);
    run_op("mult minint sq", 2'd1, 32'h80000000, 32'h80000000, 33,
           32'h40000000, 32'h0, 1'b0);

    // Second start and mthi while busy must both be ignored.
    op    = 2'd0;
    rd1   = 32'd3;
    rd2   = 32'd5;
    start = 1'b1;
    n     = 0;
    got   = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      mthi  = 1'b0;
      if (n == 5) begin
        op    = 2'd3;
        rd1   = 32'd9;
        rd2   = 32'd0;
        start = 1'b1;
        mthi  = 1'b1;
        wdata = 32'h55555555;
      end
      got = done;
    end
    chk("busy start latency", 32'(n - 1), 32'd33);
    chk("busy start hi", hi, 32'h0);
    chk("busy start lo", lo, 32'd15);
    chk("busy start dbz", 32'(div_by_zero), 32'h0);

    // Reset in the middle of a divide.
    op    = 2'd2;
    rd1   = 32'd1000;
    rd2   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    dn = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn = 1'b1;
    end
    chk("midrst no done", 32'(dn), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
